// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired control sequencer for the bus-based CPU datapath
// Fetch (F0..F2), decode at T3, opcode-specific execute up to T7, then back to fetch.
module control_unit #(
  parameter int          MEM_WAIT = 1,
  parameter logic [4:0]  OP_ADD   = 5'b00011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  input  logic        stop,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        con_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        manual_R15_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        r_enable,
  output logic        r_select,
  output logic        BAout,
  output logic        PC_select,
  output logic        HI_select,
  output logic        LO_select,
  output logic        Z_HI_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        InPort_select,
  output logic        c_select,
  output logic        OutPort_enable,
  output logic [4:0]  alu_instruction,
  output logic        run,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    S_RESET, S_PAUSE, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] wait_cnt;
  logic       wait_done, in_wait, done;
  logic [4:0] opcode;
  logic       is_rr, is_imm, is_md, is_neg, is_ld, is_ldi, is_st, is_br;
  logic       is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo, is_halt, is_undef;
  logic       unused_ir;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];
  assign is_ld     = opcode == 5'd0;
  assign is_ldi    = opcode == 5'd1;
  assign is_st     = opcode == 5'd2;
  assign is_rr     = opcode >= 5'd3 && opcode <= 5'd11;
  assign is_imm    = opcode >= 5'd12 && opcode <= 5'd14;
  assign is_md     = opcode == 5'd15 || opcode == 5'd16;
  assign is_neg    = opcode == 5'd17 || opcode == 5'd18;
  assign is_br     = opcode == 5'd19;
  assign is_jr     = opcode == 5'd20;
  assign is_jal    = opcode == 5'd21;
  assign is_in     = opcode == 5'd22;
  assign is_out    = opcode == 5'd23;
  assign is_mfhi   = opcode == 5'd24;
  assign is_mflo   = opcode == 5'd25;
  assign is_halt   = opcode == 5'd27;
  assign is_undef  = opcode >= 5'd28;

  // Memory-access states hold until wait_cnt has counted MEM_WAIT cycles.
  assign in_wait   = state == S_F1 || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
  assign wait_done = wait_cnt == 3'(MEM_WAIT - 1);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= S_RESET;
      wait_cnt   <= 3'd0;
      illegal_op <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (in_wait && !wait_done) ? wait_cnt + 3'd1 : 3'd0;
      if (state == S_T3 && is_undef)
        illegal_op <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_RESET: state_nxt = S_F0;
      S_PAUSE: if (!stop) state_nxt = S_F0;
      S_F0:    state_nxt = S_F1;
      S_F1:    if (wait_done) state_nxt = S_F2;
      S_F2:    state_nxt = S_T3;
      S_T3: begin
        if (is_halt) state_nxt = S_HALT;
        else if (is_jr || is_in || is_out || is_mfhi || is_mflo || opcode == 5'd26 || is_undef)
          done = 1'b1;
        else state_nxt = S_T4;
      end
      S_T4: if (is_neg || is_jal) done = 1'b1; else state_nxt = S_T5;
      S_T5: if (is_rr || is_imm || is_ldi) done = 1'b1; else state_nxt = S_T6;
      S_T6: begin
        if (is_md || is_br) done = 1'b1;
        else if (is_st || wait_done) state_nxt = S_T7;
      end
      S_T7: if (is_ld || wait_done) done = 1'b1;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_RESET;
    endcase
    if (done)
      state_nxt = stop ? S_PAUSE : S_F0;
  end

  always_comb begin
    {PC_enable, PC_increment_enable, IR_enable, con_enable, Y_enable, Z_enable,
     MAR_enable, MDR_enable, HI_enable, LO_enable, manual_R15_enable} = '0;
    {read, write, Gra, Grb, Grc, r_enable, r_select, BAout} = '0;
    {PC_select, HI_select, LO_select, Z_HI_select, Z_LO_select, MDR_select,
     InPort_select, c_select, OutPort_enable} = '0;
    alu_instruction = 5'd0;
    run = !(state == S_RESET || state == S_PAUSE || state == S_HALT);
    case (state)
      S_F0: {PC_select, MAR_enable, PC_increment_enable} = 3'b111;
      S_F1: {read, MDR_enable} = 2'b11;
      S_F2: {MDR_select, IR_enable} = 2'b11;
      S_T3: begin
        if (is_rr || is_imm) {Grb, r_select, Y_enable} = 3'b111;
        else if (is_neg) begin
          {Grb, r_select, Z_enable} = 3'b111;
          alu_instruction = opcode;
        end
        else if (is_md) {Gra, r_select, Y_enable} = 3'b111;
        else if (is_ld || is_ldi || is_st) {Grb, BAout, Y_enable} = 3'b111;
        else if (is_br) {Gra, r_select, con_enable} = 3'b111;
        else if (is_jr) {Gra, r_select, PC_enable} = 3'b111;
        else if (is_jal) {PC_select, manual_R15_enable} = 2'b11;
        else if (is_in) {InPort_select, Gra, r_enable} = 3'b111;
        else if (is_out) {Gra, r_select, OutPort_enable} = 3'b111;
        else if (is_mfhi) {HI_select, Gra, r_enable} = 3'b111;
        else if (is_mflo) {LO_select, Gra, r_enable} = 3'b111;
      end
      S_T4: begin
        if (is_rr || is_md) begin
          {Grc, r_select, Z_enable} = {is_rr, 2'b11};
          Grb = is_md;
          alu_instruction = opcode;
        end
        else if (is_imm) begin
          {c_select, Z_enable} = 2'b11;
          alu_instruction = opcode;
        end
        else if (is_neg) {Z_LO_select, Gra, r_enable} = 3'b111;
        else if (is_ld || is_ldi || is_st) begin
          {c_select, Z_enable} = 2'b11;
          alu_instruction = OP_ADD;
        end
        else if (is_br) {PC_select, Y_enable} = 2'b11;
        else if (is_jal) {Gra, r_select, PC_enable} = 3'b111;
      end
      S_T5: begin
        if (is_rr || is_imm || is_ldi) {Z_LO_select, Gra, r_enable} = 3'b111;
        else if (is_md) {Z_LO_select, LO_enable} = 2'b11;
        else if (is_ld || is_st) {Z_LO_select, MAR_enable} = 2'b11;
        else if (is_br) begin
          {c_select, Z_enable} = 2'b11;
          alu_instruction = OP_ADD;
        end
      end
      S_T6: begin
        if (is_md) {Z_HI_select, HI_enable} = 2'b11;
        else if (is_ld) {read, MDR_enable} = 2'b11;
        else if (is_st) {Gra, r_select, MDR_enable} = 3'b111;
        else if (is_br) {Z_LO_select, PC_enable} = {2{con_output}};
      end
      S_T7: begin
        if (is_ld) {MDR_select, Gra, r_enable} = 3'b111;
        else if (is_st) write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized check of control_unit against a per-instruction step-list model
// Two DUTs (MEM_WAIT 1 and 3) are exercised one after the other; the idle one is held in clr.
module tb_control_unit;

  typedef logic [34:0] vec_t;
  typedef vec_t vq_t[$];

  localparam vec_t PCE  = 35'h1 << 0,  PCIE = 35'h1 << 1,  IRE  = 35'h1 << 2,  CONE = 35'h1 << 3;
  localparam vec_t YE   = 35'h1 << 4,  ZE   = 35'h1 << 5,  MARE = 35'h1 << 6,  MDRE = 35'h1 << 7;
  localparam vec_t HIE  = 35'h1 << 8,  LOE  = 35'h1 << 9,  R15  = 35'h1 << 10, RD   = 35'h1 << 11;
  localparam vec_t WR   = 35'h1 << 12, GRA  = 35'h1 << 13, GRB  = 35'h1 << 14, GRC  = 35'h1 << 15;
  localparam vec_t RE   = 35'h1 << 16, RS   = 35'h1 << 17, BA   = 35'h1 << 18, PCS  = 35'h1 << 19;
  localparam vec_t HIS  = 35'h1 << 20, LOS  = 35'h1 << 21, ZHI  = 35'h1 << 22, ZLO  = 35'h1 << 23;
  localparam vec_t MDRS = 35'h1 << 24, INS  = 35'h1 << 25, CS   = 35'h1 << 26, OUTE = 35'h1 << 27;
  localparam vec_t RUN  = 35'h1 << 33, ILL  = 35'h1 << 34;

  logic        clk;
  logic        clr  [2];
  logic        stop [2];
  logic        con  [2];
  logic [31:0] ir   [2];
  vec_t        obs  [2];
  vec_t        exp_v[2];
  bit          ill_m[2];
  int          n_cmp, n_bad;
  bit          pinned;
  vq_t         pq;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic pce, pcie, ire, cone, ye, ze, mare, mdre, hie, loe, r15, rd, wr, gra, grb, grc;
    logic re, rs, ba, pcs, his, los, zhi, zlo, mdrs, ins, cs, oute, run_o, ill_o;
    logic [4:0] alu_o;
    control_unit #(.MEM_WAIT(g == 0 ? 1 : 3)) dut (
      .clk(clk), .clr(clr[g]), .IR_Data(ir[g]), .con_output(con[g]), .stop(stop[g]),
      .PC_enable(pce), .PC_increment_enable(pcie), .IR_enable(ire), .con_enable(cone),
      .Y_enable(ye), .Z_enable(ze), .MAR_enable(mare), .MDR_enable(mdre), .HI_enable(hie),
      .LO_enable(loe), .manual_R15_enable(r15), .read(rd), .write(wr), .Gra(gra), .Grb(grb),
      .Grc(grc), .r_enable(re), .r_select(rs), .BAout(ba), .PC_select(pcs), .HI_select(his),
      .LO_select(los), .Z_HI_select(zhi), .Z_LO_select(zlo), .MDR_select(mdrs),
      .InPort_select(ins), .c_select(cs), .OutPort_enable(oute), .alu_instruction(alu_o),
      .run(run_o), .illegal_op(ill_o)
    );
    assign obs[g] = {ill_o, run_o, alu_o, oute, cs, ins, mdrs, zlo, zhi, los, his, pcs, ba, rs, re,
                     grc, grb, gra, wr, rd, r15, loe, hie, mdre, mare, ze, ye, cone, ire, pcie, pce};
  end

  function automatic int mw_of(input int d);
    return d == 0 ? 1 : 3;
  endfunction

  function automatic vec_t alu(input logic [4:0] o);
    return {2'b00, o, 28'h0};
  endfunction

  // Whole-instruction list of control words, one entry per clock, fetch included.
  function automatic vq_t build(input int mw, input logic [4:0] op, input logic c);
    vq_t q;
    q.push_back(PCS | MARE | PCIE);
    repeat (mw) q.push_back(RD | MDRE);
    q.push_back(MDRS | IRE);
    if (op >= 5'd3 && op <= 5'd14) begin
      q.push_back(GRB | RS | YE);
      q.push_back((op <= 5'd11 ? (GRC | RS) : CS) | ZE | alu(op));
      q.push_back(ZLO | GRA | RE);
    end else if (op == 5'd15 || op == 5'd16) begin
      q.push_back(GRA | RS | YE);
      q.push_back(GRB | RS | ZE | alu(op));
      q.push_back(ZLO | LOE);
      q.push_back(ZHI | HIE);
    end else if (op == 5'd17 || op == 5'd18) begin
      q.push_back(GRB | RS | ZE | alu(op));
      q.push_back(ZLO | GRA | RE);
    end else if (op <= 5'd2) begin
      q.push_back(GRB | BA | YE);
      q.push_back(CS | ZE | alu(5'd3));
      if (op == 5'd1) q.push_back(ZLO | GRA | RE);
      else begin
        q.push_back(ZLO | MARE);
        if (op == 5'd0) begin
          repeat (mw) q.push_back(RD | MDRE);
          q.push_back(MDRS | GRA | RE);
        end else begin
          q.push_back(GRA | RS | MDRE);
          repeat (mw) q.push_back(WR);
        end
      end
    end else begin
      case (op)
        5'd19: begin
          q.push_back(GRA | RS | CONE);
          q.push_back(PCS | YE);
          q.push_back(CS | ZE | alu(5'd3));
          q.push_back(c ? (ZLO | PCE) : 35'h0);
        end
        5'd20: q.push_back(GRA | RS | PCE);
        5'd21: begin
          q.push_back(PCS | R15);
          q.push_back(GRA | RS | PCE);
        end
        5'd22: q.push_back(INS | GRA | RE);
        5'd23: q.push_back(GRA | RS | OUTE);
        5'd24: q.push_back(HIS | GRA | RE);
        5'd25: q.push_back(LOS | GRA | RE);
        default: q.push_back(35'h0);
      endcase
    end
    foreach (q[i]) q[i] = q[i] | RUN;
    return q;
  endfunction

  task automatic pin(input string name, input vec_t got, input vec_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL model_%s: got %h expected %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (!pinned) begin
      pinned = 1'b1;
      pq = build(1, 5'd26, 1'b0); pin("nop_len_mw1", vec_t'(pq.size()), 35'd4);
      pin("f0_word", pq[0], 35'h2_0008_0042);
      pq = build(1, 5'd3, 1'b0);  pin("add_len", vec_t'(pq.size()), 35'd6);
      pin("add_t4", pq[4], 35'h2_3002_8020);
      pq = build(3, 5'd0, 1'b0);  pin("ld_len_mw3", vec_t'(pq.size()), 35'd12);
      pq = build(3, 5'd2, 1'b0);  pin("st_len_mw3", vec_t'(pq.size()), 35'd12);
      pq = build(1, 5'd19, 1'b1); pin("br_taken_t6", pq[6], 35'h2_0080_0001);
      pq = build(1, 5'd19, 1'b0); pin("br_not_taken_t6", pq[6], 35'h2_0000_0000);
    end
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (obs[d] !== exp_v[d]) begin
        n_bad++;
        $display("FAIL dut%0d t=%0t: got %h expected %h (diff %h)", d, $time, obs[d], exp_v[d],
                 obs[d] ^ exp_v[d]);
      end
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step(input int d, input vec_t v);
    @(posedge clk);
    #1;
    exp_v[d] = v | (ill_m[d] ? ILL : 35'h0);
  endtask

  task automatic instr(input int d, input logic [31:0] iv, input logic c, input int pause);
    vq_t q = build(mw_of(d), iv[31:27], c);
    foreach (q[i]) begin
      step(d, q[i]);
      if (i == 0) begin
        ir[d]   = iv;
        con[d]  = c;
        stop[d] = pause > 0;
      end
    end
    if (iv[31:27] >= 5'd28) ill_m[d] = 1'b1;
    for (int i = 0; i < pause; i++) begin
      step(d, 35'h0);
      if (i == pause - 1) stop[d] = 1'b0;
    end
  endtask

  task automatic do_reset(input int d);
    @(posedge clk);
    #1;
    clr[d] = 1'b1; stop[d] = 1'b0; ill_m[d] = 1'b0; exp_v[d] = 35'h0;
    step(d, 35'h0);
    step(d, 35'h0);
    clr[d] = 1'b0;
  endtask

  task automatic phase(input int d);
    logic [4:0] op;
    vq_t        q;
    do_reset(d);
    instr(d, {5'd26, 27'h0}, 1'b0, 0);
    instr(d, {5'd26, 27'h0}, 1'b0, 0);
    instr(d, 32'h18A2_0000, 1'b0, 0);
    instr(d, {5'd19, 27'h0}, 1'b0, 0);
    instr(d, {5'd19, 27'h0}, 1'b1, 0);
    for (int o = 0; o <= 26; o++) instr(d, {5'(o), 27'($urandom)}, 1'($urandom), 0);
    instr(d, {5'd26, 27'h0}, 1'b0, 2);
    instr(d, {5'd31, 27'h0}, 1'b0, 0);
    instr(d, {5'd26, 27'h0}, 1'b0, 1);
    for (int k = 0; k < 40; k++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      instr(d, {op, 27'($urandom)}, 1'($urandom),
            ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    instr(d, {5'd27, 27'h0}, 1'b0, 0);
    for (int k = 0; k < 20; k++) begin
      step(d, 35'h0);
      stop[d] = 1'($urandom);
    end
    do_reset(d);
    instr(d, {5'd26, 27'h0}, 1'b0, 0);
    // Abort a store on its first write cycle with an asynchronous clr.
    q = build(mw_of(d), 5'd2, 1'b0);
    for (int i = 0; i <= q.size() - mw_of(d); i++) begin
      step(d, q[i]);
      if (i == 0) ir[d] = {5'd2, 27'($urandom)};
    end
    #2;
    clr[d] = 1'b1; ill_m[d] = 1'b0; exp_v[d] = 35'h0;
    step(d, 35'h0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      clr[d] = 1'b0; stop[d] = 1'b0; con[d] = 1'b0; ir[d] = 32'h0;
      exp_v[d] = 35'h0; ill_m[d] = 1'b0;
    end
    n_cmp = 0; n_bad = 0; pinned = 1'b0;
    #1;
    clr[0] = 1'b1; clr[1] = 1'b1;
    phase(0);
    phase(1);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
